// File: rtl/aes_uart_sequencer_if.sv
// UART-side byte handshake bundle for aes_uart_sequencer.
// master = sequencer side, slave = uart_rx/uart_tx side.
interface aes_uart_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (input rx_data, input rx_valid, input tx_ready,
                    output tx_data, output tx_valid);
    modport slave  (output rx_data, output rx_valid, output tx_ready,
                    input tx_data, input tx_valid);
endinterface

// File: rtl/aes_uart_sequencer.sv
// Sequences a combinational AES-128 encrypter behind a UART byte stream.
// Optional inter-byte timeout enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_uart_sequencer #(
    parameter int unsigned RELOAD_KEY     = 1,
    parameter int unsigned ENC_WAIT       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_uart_sequencer_if.master uart,
    output logic [0:127]         enc_clear_data,
    output logic [0:127]         enc_key,
    input  logic [0:127]         enc_data,
    output logic                 busy,
    output logic                 block_done,
    output logic                 rx_overrun
`ifdef AES_SEQ_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {RX_KEY, RX_DATA, ENCRYPT, TX} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt, wait_d;
    logic [0:BLK_W-1]   ct, ct_d, key_d, pt_d;
    logic [7:0]         tx_data_d;
    logic               tx_valid_d, block_done_d, overrun_d, busy_d;
    logic               key_loaded, key_loaded_d;
`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0]  idle_cnt, idle_d;
    logic               timeout_d;
`endif

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RX_KEY;
            byte_cnt       <= '0;
            wait_cnt       <= '0;
            ct             <= '0;
            enc_key        <= '0;
            enc_clear_data <= '0;
            uart.tx_data   <= '0;
            uart.tx_valid  <= 1'b0;
            block_done     <= 1'b0;
            rx_overrun     <= 1'b0;
            busy           <= 1'b0;
            key_loaded     <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            idle_cnt       <= '0;
            timeout        <= 1'b0;
`endif
        end else begin
            state          <= state_d;
            byte_cnt       <= byte_cnt_d;
            wait_cnt       <= wait_d;
            ct             <= ct_d;
            enc_key        <= key_d;
            enc_clear_data <= pt_d;
            uart.tx_data   <= tx_data_d;
            uart.tx_valid  <= tx_valid_d;
            block_done     <= block_done_d;
            rx_overrun     <= overrun_d;
            busy           <= busy_d;
            key_loaded     <= key_loaded_d;
`ifdef AES_SEQ_TIMEOUT_EN
            idle_cnt       <= idle_d;
            timeout        <= timeout_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        byte_cnt_d   = byte_cnt;
        wait_d       = wait_cnt;
        ct_d         = ct;
        key_d        = enc_key;
        pt_d         = enc_clear_data;
        tx_data_d    = uart.tx_data;
        tx_valid_d   = uart.tx_valid;
        block_done_d = 1'b0;
        overrun_d    = rx_overrun;
        key_loaded_d = key_loaded;
`ifdef AES_SEQ_TIMEOUT_EN
        idle_d       = '0;
        timeout_d    = 1'b0;
`endif

        case (state)
            RX_KEY: begin
                if (uart.rx_valid) begin
                    key_d[{byte_cnt, 3'b000} +: 8] = uart.rx_data;
                    byte_cnt_d = byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) begin
                        key_loaded_d = 1'b1;
                        state_d      = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (uart.rx_valid) begin
                    pt_d[{byte_cnt, 3'b000} +: 8] = uart.rx_data;
                    byte_cnt_d = byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) begin
                        wait_d  = WAIT_W'(ENC_WAIT - 1);
                        state_d = ENCRYPT;
                    end
                end
            end
            ENCRYPT: begin
                if (uart.rx_valid) overrun_d = 1'b1;
                if (wait_cnt == '0) begin
                    ct_d    = enc_data;
                    state_d = TX;
                end else begin
                    wait_d = wait_cnt - 8'd1;
                end
            end
            TX: begin
                if (uart.rx_valid) overrun_d = 1'b1;
                // First TX cycle only raises valid; the captured block is already in ct
                if (!uart.tx_valid) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = ct[0:7];
                end else if (uart.tx_ready) begin
                    if (byte_cnt == 4'd15) begin
                        tx_valid_d   = 1'b0;
                        block_done_d = 1'b1;
                        byte_cnt_d   = '0;
                        state_d      = (RELOAD_KEY != 0) ? RX_KEY : RX_DATA;
                    end else begin
                        byte_cnt_d = byte_cnt + 4'd1;
                        tx_data_d  = ct[{byte_cnt_d, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = RX_KEY;
        endcase

`ifdef AES_SEQ_TIMEOUT_EN
        // Abandon a stalled partial frame; a partial key never counts as loaded
        if ((state == RX_KEY || state == RX_DATA) && byte_cnt != '0 && !uart.rx_valid) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_d  = 1'b1;
                byte_cnt_d = '0;
                state_d    = (key_loaded && RELOAD_KEY == 0) ? RX_DATA : RX_KEY;
            end else begin
                idle_d = idle_cnt + 1'b1;
            end
        end
`endif

        busy_d = !((state_d == RX_KEY || state_d == RX_DATA) && byte_cnt_d == '0);
    end

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Scoreboard bench for aes_uart_sequencer: behavioural AES-128 stands in for the encrypter
// and predicts ciphertext; two instances cover RELOAD_KEY = 1 and RELOAD_KEY = 0.
module tb_aes_uart_sequencer;

    localparam int unsigned EW0 = 4;
    localparam int unsigned EW1 = 1;
    localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_uart_sequencer_if u0 ();
    aes_uart_sequencer_if u1 ();

    logic [0:127] key0, pt0, enc0, key1, pt1, enc1;
    logic busy0, done0, ovr0, busy1, done1, ovr1;
`ifdef AES_SEQ_TIMEOUT_EN
    logic to0, to1;
`endif

    aes_uart_sequencer #(.RELOAD_KEY(1), .ENC_WAIT(EW0)
`ifdef AES_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(50)
`endif
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .uart(u0),
        .enc_clear_data(pt0), .enc_key(key0), .enc_data(enc0),
        .busy(busy0), .block_done(done0), .rx_overrun(ovr0)
`ifdef AES_SEQ_TIMEOUT_EN
        , .timeout(to0)
`endif
    );

    aes_uart_sequencer #(.RELOAD_KEY(0), .ENC_WAIT(EW1)
`ifdef AES_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(50)
`endif
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .uart(u1),
        .enc_clear_data(pt1), .enc_key(key1), .enc_data(enc1),
        .busy(busy1), .block_done(done1), .rx_overrun(ovr1)
`ifdef AES_SEQ_TIMEOUT_EN
        , .timeout(to1)
`endif
    );

    // ---------------- behavioural AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse in GF(2^8) as x^254, then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] aes_enc(input logic [0:127] key, input logic [0:127] pt);
        logic [7:0] s[16];
        logic [7:0] k[16];
        logic [7:0] t[16];
        logic [7:0] g[4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [0:127] out;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[8*i +: 8];
            s[i] = pt[8*i +: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            g[0] = sbox(k[13]) ^ rc;
            g[1] = sbox(k[14]);
            g[2] = sbox(k[15]);
            g[3] = sbox(k[12]);
            for (int i = 0; i < 4; i++)  k[i] = k[i] ^ g[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++)
                t[i] = sbox(s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]);
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) out[8*i +: 8] = s[i];
        return out;
    endfunction

    assign enc0 = aes_enc(key0, pt0);
    assign enc1 = aes_enc(key1, pt1);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int acc0 = 0;
    logic bp = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int which, input logic [0:127] ct);
        for (int i = 0; i < 16; i++) begin
            if (which == 0) exp0.push_back(ct[8*i +: 8]);
            else            exp1.push_back(ct[8*i +: 8]);
        end
    endtask

    // Monitors: a transfer seen at the falling edge completes on the next rising edge
    int idx0 = 0, idx1 = 0;
    logic pend0 = 1'b0, pend1 = 1'b0, stall0 = 1'b0;
    logic [7:0] prev0 = 8'h00;
    logic [7:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            idx0 = 0; idx1 = 0; pend0 = 1'b0; pend1 = 1'b0; stall0 = 1'b0;
        end else begin
            if (pend0 || done0) check("block_done0", 128'(done0), 128'(pend0));
            if (pend1 || done1) check("block_done1", 128'(done1), 128'(pend1));
            pend0 = 1'b0;
            pend1 = 1'b0;
            if (stall0) check("tx_hold0", {119'd0, u0.tx_valid, u0.tx_data}, {119'd0, 1'b1, prev0});
            stall0 = u0.tx_valid && !u0.tx_ready;
            prev0  = u0.tx_data;
            if (u0.tx_valid && u0.tx_ready) begin
                if (exp0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_extra0: got %h expected no byte", u0.tx_data);
                end else begin
                    e = exp0.pop_front();
                    check("tx_byte0", 128'(u0.tx_data), 128'(e));
                end
                acc0++;
                idx0++;
                if (idx0 == 16) begin idx0 = 0; pend0 = 1'b1; end
            end
            if (u1.tx_valid && u1.tx_ready) begin
                if (exp1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_extra1: got %h expected no byte", u1.tx_data);
                end else begin
                    e = exp1.pop_front();
                    check("tx_byte1", 128'(u1.tx_data), 128'(e));
                end
                idx1++;
                if (idx1 == 16) begin idx1 = 0; pend1 = 1'b1; end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        u0.tx_ready = 1'b0;
        u1.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            u0.tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            u1.tx_ready = 1'b1;
        end
    end

    task automatic send_byte(input int which, input logic [7:0] b);
        if (which == 0) begin u0.rx_data = b; u0.rx_valid = 1'b1; end
        else            begin u1.rx_data = b; u1.rx_valid = 1'b1; end
        tick();
        u0.rx_valid = 1'b0;
        u1.rx_valid = 1'b0;
    endtask

    task automatic send_block(input int which, input logic [0:127] blk);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) repeat ($urandom_range(0, 2)) tick();
            send_byte(which, blk[8*i +: 8]);
        end
    endtask

    function automatic logic txv(input int which);
        return (which == 0) ? u0.tx_valid : u1.tx_valid;
    endfunction

    // Send frame(s), queue the expected ciphertext, check first-byte latency
    task automatic start_txn(input int which, input logic send_key, input logic [0:127] key,
                             input logic [0:127] pt, input logic [0:127] ct, input logic inject);
        int k;
        if (send_key) send_block(which, key);
        push_exp(which, ct);
        send_block(which, pt);
        k = 0;
        if (inject) begin
            u0.rx_data = 8'hAA; u0.rx_valid = 1'b1;
            tick();
            u0.rx_valid = 1'b0;
            k = 1;
        end
        while (k < 100 && !txv(which)) begin
            tick();
            k++;
        end
        check(which == 0 ? "latency0" : "latency1", 128'(k), 128'(which == 0 ? EW0 + 1 : EW1 + 1));
        check("busy_in_tx", 128'(which == 0 ? busy0 : busy1), 128'd1);
    endtask

    task automatic finish_txn(input int which);
        int k;
        k = 0;
        while (k < 500 && ((which == 0 ? exp0.size() : exp1.size()) != 0 || txv(which))) begin
            tick();
            k++;
        end
        check("drain", 128'(k < 500), 128'd1);
        tick();
        tick();
        check("busy_idle", 128'(which == 0 ? busy0 : busy1), 128'd0);
    endtask

    task automatic check_reset_outputs;
        check("rst_tx", {118'd0, u0.tx_valid, u0.tx_data, busy0, done0, ovr0}, 128'd0);
        check("rst_key", key0, 128'd0);
        check("rst_pt", pt0, 128'd0);
        check("rst_tx1", {118'd0, u1.tx_valid, u1.tx_data, busy1, done1, ovr1}, 128'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [0:127] rk, rp;
        int k;
        u0.rx_data = 8'h00; u0.rx_valid = 1'b0;
        u1.rx_data = 8'h00; u1.rx_valid = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // FIPS-197 vector, constant expectation, no backpressure
        start_txn(0, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0);
        finish_txn(0);

        // Same vector under random backpressure
        bp = 1'b1;
        start_txn(0, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0);
        finish_txn(0);

        // Random key/plaintext against the behavioural model
        for (int n = 0; n < 4; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            start_txn(0, 1'b1, rk, rp, aes_enc(rk, rp), 1'b0);
            finish_txn(0);
        end

        // Overrun during ENCRYPT: sticky flag, ciphertext intact
        check("ovr_before", 128'(ovr0), 128'd0);
        start_txn(0, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b1);
        finish_txn(0);
        check("ovr_set", 128'(ovr0), 128'd1);
        rk = {$urandom, $urandom, $urandom, $urandom};
        start_txn(0, 1'b1, rk, FIPS_PT, aes_enc(rk, FIPS_PT), 1'b0);
        finish_txn(0);
        check("ovr_sticky", 128'(ovr0), 128'd1);

        // Reset after five ciphertext bytes
        bp = 1'b0;
        acc0 = 0;
        start_txn(0, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0);
        k = 0;
        while (acc0 < 5 && k < 100) begin tick(); k++; end
        check("five_sent", 128'(acc0 >= 5), 128'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp0.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start_txn(0, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0);
        finish_txn(0);

        // RELOAD_KEY = 0: key only on the first transaction
        start_txn(1, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0);
        finish_txn(1);
        start_txn(1, 1'b0, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0);
        finish_txn(1);
        rp = {$urandom, $urandom, $urandom, $urandom};
        start_txn(1, 1'b0, FIPS_KEY, rp, aes_enc(FIPS_KEY, rp), 1'b0);
        finish_txn(1);
        check("key1_retained", key1, FIPS_KEY);

`ifdef AES_SEQ_TIMEOUT_EN
        // Stalled partial key abandons the frame
        for (int i = 0; i < 7; i++) send_byte(0, 8'(i));
        k = 0;
        while (k < 60 && !to0) begin tick(); k++; end
        check("timeout_pulse", 128'(to0), 128'd1);
        tick();
        check("timeout_idle", 128'(busy0), 128'd0);
        start_txn(0, 1'b1, FIPS_KEY, FIPS_PT, FIPS_CT, 1'b0);
        finish_txn(0);
`endif

        check("queue0_empty", 128'(exp0.size()), 128'd0);
        check("queue1_empty", 128'(exp1.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
